// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and state type for the instruction fetch unit.
package fetch_pkg;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam logic [DW-1:0] HALT_WORD = 16'h0001;
    localparam logic [AW-1:0] PC_INC = 8'd2;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit.sv
// PC/fetch stage feeding decode: sequential fetch, redirects, stalls, HALT freeze/resume.
// Optional fetch counter built when INSTR_FETCH_COUNT_EN is defined.
module instr_fetch_unit
    import fetch_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET,
    input  logic          STALL,
    input  logic          BR_TAKEN,
    input  logic [AW-1:0] BR_TARGET,
    input  logic          RESUME,
    output logic [AW-1:0] IRAM_ADDR,
    input  logic [DW-1:0] IRAM_Q,
    output logic [DW-1:0] IR,
    output logic          IR_VALID,
    output logic [AW-1:0] IR_PC,
    output logic          HALTED,
    output logic [15:0]   FETCH_CNT
);
    fetch_state_t  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [AW-1:0] ir_pc_q, ir_pc_d;
    logic          vld_q, vld_d;
    logic          halted_q, halted_d;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ir_pc_d  = ir_pc_q;
        vld_d    = vld_q;
        halted_d = halted_q;
        case (state_q)
            RUN: begin
                if (BR_TAKEN) begin
                    // Wrong-path word is squashed; bit 0 of the target is dropped.
                    pc_d  = BR_TARGET & {{(AW-1){1'b1}}, 1'b0};
                    vld_d = 1'b0;
                end else if (!STALL) begin
                    ir_d    = IRAM_Q;
                    ir_pc_d = pc_q;
                    vld_d   = 1'b1;
                    pc_d    = pc_q + PC_INC;
                    if (IRAM_Q == HALT_WORD) begin
                        state_d  = fetch_pkg::HALTED;
                        halted_d = 1'b1;
                    end
                end
            end
            fetch_pkg::HALTED: begin
                vld_d = 1'b0;
                if (RESUME) begin
                    state_d  = RUN;
                    halted_d = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= RUN;
            pc_q     <= '0;
            ir_q     <= '0;
            ir_pc_q  <= '0;
            vld_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ir_pc_q  <= ir_pc_d;
            vld_q    <= vld_d;
            halted_q <= halted_d;
        end
    end

`ifdef INSTR_FETCH_COUNT_EN
    logic        fetch_en;
    logic [15:0] cnt_q;

    assign fetch_en = (state_q == RUN) && !BR_TAKEN && !STALL;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)         cnt_q <= '0;
        else if (fetch_en) cnt_q <= cnt_q + 16'd1;
    end

    assign FETCH_CNT = cnt_q;
`else
    assign FETCH_CNT = 16'h0000;
`endif

    assign IRAM_ADDR = pc_q;
    assign IR        = ir_q;
    assign IR_VALID  = vld_q;
    assign IR_PC     = ir_pc_q;
    assign HALTED    = halted_q;
endmodule
